// File: rtl/mon_exp_ctrl_pkg.sv
// Shared definitions for the modular-exponentiation sequencer and mon_prod:
// operation codes, datapath sizing and the operand memory map.
package mon_exp_ctrl_pkg;

  localparam int unsigned BITLEN = 32;
  localparam int unsigned DBITS  = BITLEN / 2;
  localparam int unsigned ABITS  = 2;

  localparam logic [ABITS-1:0] X_LO = 2'd0;
  localparam logic [ABITS-1:0] X_HI = 2'd1;
  localparam logic [ABITS-1:0] M_LO = 2'd2;
  localparam logic [ABITS-1:0] M_HI = 2'd3;

  typedef enum logic [1:0] {
    OPXX = 2'd0,
    OPXM = 2'd1,
    OPX1 = 2'd2
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StArm,
    StWait,
    StNext,
    StDone
  } state_e;

endpackage

// File: rtl/mon_exp_ctrl_if.sv
// Start/op_code/stop handshake between the exponentiation sequencer (master)
// and the Montgomery product engine (slave).
interface mon_exp_ctrl_if
  import mon_exp_ctrl_pkg::*;
#(
  parameter int unsigned CW = 10
) ();

  logic          mp_start;
  op_e           mp_op_code;
  logic [CW-1:0] mp_count;
  logic          mp_stop;

  modport master (
    output mp_start,
    output mp_op_code,
    output mp_count,
    input  mp_stop
  );

  modport slave (
    input  mp_start,
    input  mp_op_code,
    input  mp_count,
    output mp_stop
  );

endinterface

// File: rtl/mon_exp_ctrl_mp_watchdog.sv
// Per-operation watchdog: cleared when an operation is issued, counts while
// waiting for completion and flags the terminal count.
module mp_watchdog #(
  parameter int unsigned W       = 12,
  parameter int unsigned TIMEOUT = 2048
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = en && (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/mon_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer: issues one mon_prod operation
// per step over the exponent bits, then converts the result out of Montgomery form.
module mon_exp_ctrl
  import mon_exp_ctrl_pkg::*;
#(
  parameter int unsigned EBITS   = 1024,
  parameter int unsigned ELW     = 11,
  parameter int unsigned CW      = 10,
  parameter int unsigned TIMEOUT = 2048
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [EBITS-1:0] exp,
  input  logic [ELW-1:0]   exp_len,
  input  logic [CW-1:0]    mp_count_cfg,
  mon_exp_ctrl_if.master   mp,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [11:0]      op_cnt
);

  localparam int unsigned    IW     = (EBITS > 1) ? $clog2(EBITS) : 1;
  localparam logic [ELW-1:0] EBitsL = ELW'(EBITS);

  state_e           state_q;
  op_e              cur_op_q;
  logic [IW-1:0]    bit_idx_q;
  logic [EBITS-1:0] exp_q;
  logic [CW-1:0]    count_q;
  logic             start_q;
  logic             wd_expired;
  logic [ELW-1:0]   len_sat;

  assign len_sat = (exp_len > EBitsL) ? EBitsL : exp_len;

  assign mp.mp_start   = start_q;
  assign mp.mp_op_code = cur_op_q;
  assign mp.mp_count   = count_q;

  mp_watchdog #(
    .W       (CW + 2),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == StIssue),
    .en      (state_q == StWait),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cur_op_q  <= OPXX;
      bit_idx_q <= '0;
      exp_q     <= '0;
      count_q   <= '0;
      start_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      op_cnt    <= '0;
    end else begin
      start_q <= 1'b0;
      done    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go) begin
            exp_q   <= exp;
            count_q <= mp_count_cfg;
            op_cnt  <= '0;
            error   <= 1'b0;
            busy    <= 1'b1;
            start_q <= 1'b1;
            if (len_sat == '0) begin
              cur_op_q <= OPX1;
            end else begin
              bit_idx_q <= IW'(len_sat - 1'b1);
              cur_op_q  <= OPXX;
            end
            state_q <= StIssue;
          end
        end
        StIssue: begin
          op_cnt  <= op_cnt + 1'b1;
          state_q <= StArm;
        end
        // mp_stop still reflects the previous operation here.
        StArm: state_q <= StWait;
        StWait: begin
          if (mp.mp_stop) begin
            state_q <= StNext;
          end else if (wd_expired) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        StNext: begin
          if (cur_op_q == OPXX && exp_q[bit_idx_q]) begin
            cur_op_q <= OPXM;
            start_q  <= 1'b1;
            state_q  <= StIssue;
          end else if (cur_op_q == OPX1) begin
            done    <= 1'b1;
            state_q <= StDone;
          end else if (bit_idx_q == '0) begin
            cur_op_q <= OPX1;
            start_q  <= 1'b1;
            state_q  <= StIssue;
          end else begin
            bit_idx_q <= bit_idx_q - 1'b1;
            cur_op_q  <= OPXX;
            start_q   <= 1'b1;
            state_q   <= StIssue;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mon_exp_ctrl.sv
// Directed and randomized bench for mon_exp_ctrl with a behavioural mon_prod
// stand-in doing Montgomery products modulo 13 with R = 16.
module tb_mon_exp_ctrl;
  import mon_exp_ctrl_pkg::*;

  localparam int unsigned EBITS   = 1024;
  localparam int unsigned ELW     = 11;
  localparam int unsigned CW      = 10;
  localparam int unsigned TIMEOUT = 2048;
  localparam int unsigned MOD     = 13;
  localparam int unsigned RMOD    = 16;
  localparam int unsigned RINV    = 9;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             go;
  logic [EBITS-1:0] exp;
  logic [ELW-1:0]   exp_len;
  logic [CW-1:0]    mp_count_cfg;
  logic             busy, done, error;
  logic [11:0]      op_cnt;

  always #5 clk = ~clk;

  mon_exp_ctrl_if #(.CW(CW)) mp_bus ();

  mon_exp_ctrl #(
    .EBITS   (EBITS),
    .ELW     (ELW),
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .go           (go),
    .exp          (exp),
    .exp_len      (exp_len),
    .mp_count_cfg (mp_count_cfg),
    .mp           (mp_bus),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .op_cnt       (op_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Stand-in mon_prod: 0 = normal, 1 = stop stuck high, 2 = never completes
  int          stub_mode = 0;
  int          stub_err  = 0;
  int          cyc       = 0;
  int unsigned lat       = 0;
  bit          active    = 1'b0;
  logic [1:0]  held_op;
  logic [15:0] mem [4];
  logic [1:0]  op_q [$];
  int          start_cyc [$];

  function automatic int unsigned mont(input int unsigned a, input int unsigned b);
    return (a * b * RINV) % MOD;
  endfunction

  function automatic int unsigned ref_pow(input int unsigned x, input int unsigned e);
    int unsigned r = 1;
    for (int unsigned i = 0; i < e; i++) r = (r * x) % MOD;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    int unsigned a, b, r;
    if (cyc == 0) mp_bus.mp_stop <= 1'b0;
    if (stub_mode == 1) mp_bus.mp_stop <= 1'b1;
    if (mp_bus.mp_start) begin
      op_q.push_back(mp_bus.mp_op_code);
      start_cyc.push_back(cyc);
      held_op <= mp_bus.mp_op_code;
      if (stub_mode != 1) begin
        mp_bus.mp_stop <= 1'b0;
        active         <= 1'b1;
        lat            <= $urandom_range(5, 1);
      end
    end else if (active) begin
      if (mp_bus.mp_op_code !== held_op) stub_err++;
      if (stub_mode == 0) begin
        if (lat <= 1) begin
          a = int'({mem[1], mem[0]});
          b = (held_op == OPXM) ? int'({mem[3], mem[2]}) : (held_op == OPXX) ? a : 1;
          r = mont(a, b);
          mem[0] = r[15:0];
          mem[1] = r[31:16];
          mp_bus.mp_stop <= 1'b1;
          active         <= 1'b0;
        end else begin
          lat <= lat - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [EBITS-1:0] rand_exp();
    logic [EBITS-1:0] v;
    for (int i = 0; i < EBITS / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Called at a sample point while the DUT idles; returns one cycle after done.
  task automatic run(input logic [EBITS-1:0] e, input int unsigned len, input int unsigned xv,
                     input bit chk_res, input bit mid_go, input bit chk_space,
                     input string tag);
    int unsigned      len_eff, nexp, ebits_val;
    int               s_err0;
    logic [EBITS-1:0] mask;
    logic [1:0]       exp_ops [$];
    logic [CW-1:0]    cfg;
    bit               saw_done, seen_start, chk1, ok;
    len_eff = (len > EBITS) ? EBITS : len;
    mask = '0;
    for (int i = 0; i < int'(len_eff); i++) mask[i] = 1'b1;
    for (int i = int'(len_eff) - 1; i >= 0; i--) begin
      exp_ops.push_back(OPXX);
      if (e[i]) exp_ops.push_back(OPXM);
    end
    exp_ops.push_back(OPX1);
    nexp = len_eff + $countones(e & mask) + 1;
    cfg  = CW'($urandom);
    mem[0] = 16'(RMOD % MOD);
    mem[1] = 16'd0;
    mem[2] = 16'((xv * RMOD) % MOD);
    mem[3] = 16'd0;
    op_q.delete();
    start_cyc.delete();
    s_err0 = stub_err;
    saw_done = 1'b0;
    seen_start = 1'b0;
    chk1 = 1'b0;
    exp = e;
    exp_len = ELW'(len);
    mp_count_cfg = cfg;
    for (int c = 0; c < 40000; c++) begin
      go = (c == 0) || (mid_go && c == 6);
      if (c == 6 && mid_go) begin
        exp = ~e;
        exp_len = ELW'(3);
      end
      @(posedge clk);
      #1;
      if (seen_start && !chk1) begin
        check({tag, " op_cnt_first"}, op_cnt, 1);
        chk1 = 1'b1;
      end
      if (mp_bus.mp_start) seen_start = 1'b1;
      if (done) begin
        saw_done = 1'b1;
        break;
      end
      if (error && c > 0) break;
    end
    go = 1'b0;
    check({tag, " done_seen"}, saw_done, 1);
    check({tag, " busy_at_done"}, busy, 1);
    check({tag, " op_cnt"}, op_cnt, nexp);
    check({tag, " mp_count"}, mp_bus.mp_count, cfg);
    check({tag, " error"}, error, 0);
    @(posedge clk);
    #1;
    check({tag, " busy_after"}, busy, 0);
    check({tag, " done_pulse"}, done, 0);
    check({tag, " n_ops"}, op_q.size(), nexp);
    ok = (op_q.size() == exp_ops.size());
    for (int i = 0; ok && i < exp_ops.size(); i++) if (op_q[i] !== exp_ops[i]) ok = 1'b0;
    check({tag, " op_seq"}, ok, 1);
    check({tag, " opcode_stable"}, stub_err - s_err0, 0);
    if (chk_space) begin
      ok = 1'b1;
      for (int i = 1; i < start_cyc.size(); i++)
        if (start_cyc[i] - start_cyc[i-1] != 4) ok = 1'b0;
      check({tag, " start_spacing"}, ok, 1);
    end
    if (chk_res) begin
      ebits_val = int'(e[15:0] & mask[15:0]);
      check({tag, " result"}, {mem[1], mem[0]}, ref_pow(xv, ebits_val));
    end
  endtask

  initial begin
    int n;
    bit saw_done;
    rst_n = 1'b0;
    go = 1'b0;
    exp = '0;
    exp_len = '0;
    mp_count_cfg = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst error", error, 0);
    check("rst op_cnt", op_cnt, 0);
    check("rst mp_bus", {mp_bus.mp_start, mp_bus.mp_op_code, mp_bus.mp_count}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(EBITS'(4'b1011), 4, 5, 1'b1, 1'b0, 1'b0, "e1011");
    run('0, 0, 7, 1'b1, 1'b0, 1'b0, "len0");
    run(EBITS'(2'b11), 2, 5, 1'b1, 1'b0, 1'b0, "x5e3");
    run(rand_exp(), $urandom_range(16, 1), $urandom_range(12, 1), 1'b1, 1'b1, 1'b0, "midgo");
    for (int i = 0; i < 4; i++)
      run(rand_exp(), $urandom_range(16, 1), $urandom_range(12, 1), 1'b1, 1'b0, 1'b0, "rand");
    run(rand_exp(), 1500, 3, 1'b0, 1'b0, 1'b0, "sat");

    stub_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    run(rand_exp(), 5, 2, 1'b0, 1'b0, 1'b1, "stophigh");

    stub_mode = 2;
    @(posedge clk);
    #1;
    exp = rand_exp();
    exp_len = ELW'(5);
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    check("to start", mp_bus.mp_start, 1);
    n = 0;
    saw_done = 1'b0;
    while (n < 3000 && !error) begin
      @(posedge clk);
      #1;
      n++;
      if (done) saw_done = 1'b1;
    end
    check("to latency", n, TIMEOUT + 2);
    check("to error", error, 1);
    check("to busy", busy, 0);
    check("to no_done", saw_done, 0);
    check("to op_cnt", op_cnt, 1);
    stub_mode = 0;
    repeat (8) @(posedge clk);
    #1;
    run(EBITS'(4'b0110), 4, 4, 1'b1, 1'b0, 1'b0, "after_to");

    stub_mode = 2;
    exp = rand_exp();
    exp_len = ELW'(6);
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst busy", busy, 0);
    check("mid_rst op_cnt", op_cnt, 0);
    check("mid_rst flags", {done, error}, 0);
    check("mid_rst mp_bus", {mp_bus.mp_start, mp_bus.mp_op_code, mp_bus.mp_count}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stub_mode = 0;
    repeat (8) @(posedge clk);
    #1;
    run(EBITS'(3'b101), 3, 6, 1'b1, 1'b0, 1'b0, "post_rst");
    run(EBITS'(5'b11011), 5, 11, 1'b1, 1'b0, 1'b0, "b2b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
